// File: rtl/projection_issuer_pkg.sv
// Shared types and width helpers for the check-node projection issuer.
// The tag carries the check index in its low bits and the frame id above it.
package projection_issuer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } issuerState_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rest;
    result = 0;
    rest = (value > 0) ? value - 1 : 0;
    while (rest > 0) begin
      result++;
      rest = rest >> 1;
    end
    return result;
  endfunction

  function automatic int unsigned frameWidth(input int unsigned tagWidth, input int unsigned indexWidth);
    return tagWidth - indexWidth;
  endfunction

endpackage

// File: rtl/projection_issuer_prefetch_fifo2.sv
// Two-entry prefetch FIFO holding read vectors with their check index.
// Entry 0 is always the head; a pop shifts entry 1 down.
module prefetch_fifo2 #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DATA_WIDTH-1:0]  pushData,
  input  logic [INDEX_WIDTH-1:0] pushIndex,
  input  logic                   pop,
  output logic                   headValid,
  output logic [DATA_WIDTH-1:0]  headData,
  output logic [INDEX_WIDTH-1:0] headIndex,
  output logic [1:0]             occupancy
);

  logic [DATA_WIDTH-1:0]  data1;
  logic [INDEX_WIDTH-1:0] index1;
  logic [1:0]             count;
  logic                   doPop;
  logic                   doPush;

  assign doPop     = pop && (count != 2'd0);
  assign doPush    = push && ((count != 2'd2) || doPop);
  assign headValid = (count != 2'd0);
  assign occupancy = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      headData  <= '0;
      headIndex <= '0;
      data1     <= '0;
      index1    <= '0;
      count     <= '0;
    end else begin
      if (doPop) begin
        headData  <= data1;
        headIndex <= index1;
      end
      // Later assignment wins: a push into a head that is empty or leaving overrides the shift.
      if (doPush) begin
        if ((count == 2'd0) || ((count == 2'd1) && doPop)) begin
          headData  <= pushData;
          headIndex <= pushIndex;
        end else begin
          data1  <= pushData;
          index1 <= pushIndex;
        end
      end
      count <= count + 2'(doPush) - 2'(doPop);
    end
  end

endmodule

// File: rtl/projection_issuer.sv
// Frame driver for the projection pipeline: fetches vectors, issues them tagged,
// writes returning results back by index and signals frame completion.
module projection_issuer
  import projection_issuer_pkg::*;
#(
  parameter int TAG_WIDTH       = 32,
  parameter int BLOCKLENGTH     = 1,
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [ADDR_WIDTH-1:0]             num_checks,
  output logic                              idle,
  output logic                              done,
  output logic                              tag_error,
  output logic                              rd_en,
  output logic [ADDR_WIDTH-1:0]             rd_addr,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] rd_data,
  output logic                              pipe_valid,
  output logic [TAG_WIDTH-1:0]              pipe_tag,
  output logic [DATA_WIDTH*BLOCKLENGTH-1:0] pipe_data,
  input  logic                              pipe_ready,
  input  logic                              pipe_busy,
  input  logic                              res_valid,
  input  logic [TAG_WIDTH-1:0]              res_tag,
  input  logic [DATA_WIDTH*BLOCKLENGTH-1:0] res_data,
  output logic                              res_ready,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [DATA_WIDTH*BLOCKLENGTH-1:0] wr_data
);

  localparam int unsigned FRAME_WIDTH  = frameWidth(TAG_WIDTH, ADDR_WIDTH);
  localparam int unsigned VEC_WIDTH    = DATA_WIDTH * BLOCKLENGTH;
  localparam int unsigned CREDIT_WIDTH = clog2(MAX_OUTSTANDING + 1);

  issuerState_t            state;
  logic [ADDR_WIDTH-1:0]   numChecks;
  logic [ADDR_WIDTH-1:0]   fetchIdx;
  logic [ADDR_WIDTH-1:0]   readIndex;
  logic [FRAME_WIDTH-1:0]  frameId;
  logic [CREDIT_WIDTH-1:0] credits;
  logic                    readPending;
  logic [1:0]              fifoCount;
  logic [1:0]              fifoLoad;
  logic [ADDR_WIDTH-1:0]   headIndex;
  logic                    headValid;
  logic                    issue;
  logic                    resAccept;
  logic                    frameMatch;
  logic                    fetchDone;
  logic                    drainDone;

  prefetch_fifo2 #(
    .DATA_WIDTH (VEC_WIDTH),
    .INDEX_WIDTH(ADDR_WIDTH)
  ) prefetch (
    .clk      (clk),
    .reset    (reset),
    .push     (readPending),
    .pushData (rd_data),
    .pushIndex(readIndex),
    .pop      (issue),
    .headValid(headValid),
    .headData (pipe_data),
    .headIndex(headIndex),
    .occupancy(fifoCount)
  );

  // Counting the slot freed by this cycle's issue keeps one issue per cycle sustained.
  assign issue      = headValid && pipe_ready;
  assign fifoLoad   = fifoCount + 2'(readPending) - 2'(issue);
  assign rd_en      = (state == RUN) && (fetchIdx < numChecks)
                      && (credits < CREDIT_WIDTH'(MAX_OUTSTANDING)) && (fifoLoad < 2'd2);
  assign rd_addr    = fetchIdx;
  assign pipe_valid = headValid;
  assign pipe_tag   = {frameId, headIndex};
  assign res_ready  = (state == RUN) || (state == DRAIN);
  assign resAccept  = res_valid && res_ready;
  assign frameMatch = (res_tag[TAG_WIDTH-1:ADDR_WIDTH] == frameId);
  assign fetchDone  = (fetchIdx == numChecks) && !readPending && !headValid;
  assign drainDone  = (credits == '0) && !pipe_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      idle        <= 1'b1;
      done        <= 1'b0;
      tag_error   <= 1'b0;
      numChecks   <= '0;
      fetchIdx    <= '0;
      readIndex   <= '0;
      frameId     <= '0;
      credits     <= '0;
      readPending <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      done        <= 1'b0;
      wr_en       <= 1'b0;
      readPending <= rd_en;
      if (rd_en) begin
        readIndex <= fetchIdx;
        fetchIdx  <= fetchIdx + 1'b1;
      end
      credits <= credits + CREDIT_WIDTH'(rd_en) - CREDIT_WIDTH'(resAccept);
      if (resAccept) begin
        if (frameMatch) begin
          wr_en   <= 1'b1;
          wr_addr <= res_tag[ADDR_WIDTH-1:0];
          wr_data <= res_data;
        end else begin
          tag_error <= 1'b1;
        end
      end
      case (state)
        IDLE: begin
          if (start) begin
            state     <= RUN;
            idle      <= 1'b0;
            numChecks <= num_checks;
            fetchIdx  <= '0;
            frameId   <= frameId + 1'b1;
            tag_error <= 1'b0;
          end
        end
        RUN: begin
          if (fetchDone) state <= DRAIN;
        end
        DRAIN: begin
          if (drainDone) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          idle  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_projection_issuer.sv
// Bench for projection_issuer: memory and delayed-pipeline models with issue/write scoreboards,
// a table of frame scenarios and a hand-written mid-frame reset sequence.
module tb_projection_issuer;

  localparam int TW = 32;
  localparam int BL = 1;
  localparam int DW = 8;
  localparam int AW = 10;
  localparam int MO = 16;
  localparam int VW = DW * BL;
  localparam int FW = TW - AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] num_checks = '0;
  logic          idle, done, tag_error, rd_en, pipe_valid, res_ready, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [VW-1:0] rd_data = '0;
  logic [VW-1:0] res_data = '0;
  logic [VW-1:0] pipe_data, wr_data;
  logic [TW-1:0] pipe_tag;
  logic [TW-1:0] res_tag = '0;
  logic          pipe_ready = 1'b0;
  logic          pipe_busy = 1'b0;
  logic          res_valid = 1'b0;

  always #5 clk = ~clk;

  projection_issuer #(
    .TAG_WIDTH      (TW),
    .BLOCKLENGTH    (BL),
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_checks(num_checks),
    .idle(idle), .done(done), .tag_error(tag_error),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pipe_valid(pipe_valid), .pipe_tag(pipe_tag), .pipe_data(pipe_data),
    .pipe_ready(pipe_ready), .pipe_busy(pipe_busy),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data), .res_ready(res_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  typedef struct {logic [TW-1:0] tag; logic [VW-1:0] data; int readyAt;} resT;
  typedef struct {logic [TW-1:0] tag; logic [VW-1:0] data;} issT;
  typedef struct {logic [AW-1:0] addr; logic [VW-1:0] data;} wrT;
  typedef struct {
    int n; int readyMode; int delay; int stall; int busyHold;
    int corruptIdx; int expDone; int expMaxOut; int expTagErr;
  } caseT;

  logic [VW-1:0] mem [1 << AW];
  resT pipeQ[$];
  issT expIss[$];
  wrT  expWr[$];

  int nVec = 0, nErr = 0;
  int cycle = 0, startCycle = 0;
  int reads = 0, issues = 0, writes = 0, doneCnt = 0, doneCycle = -1;
  int firstRd = -1, firstValid = -1, outst = 0, maxOut = 0;
  int readyMode = 1, delay = 1, stallLen = 0, busyLen = 0, corruptIdx = -1;
  int stallUntil = 0, busyUntil = 0;
  bit startReq = 0, heldValid = 0, resAcc = 0;
  logic [TW-1:0] heldTag;
  logic [VW-1:0] heldData;
  logic [VW-1:0] pendRd = '0;
  logic [FW-1:0] expFrame = '0;

  function automatic logic [VW-1:0] proj(input logic [VW-1:0] d);
    return ~d + VW'(1);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string what);
    nVec++;
    nErr++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Per-cycle environment: drive inputs at the falling edge, sample shortly after.
  always @(negedge clk) begin
    issT e;
    wrT  w;
    logic [TW-1:0] t;
    cycle++;
    rd_data = pendRd;
    start = 1'b0;
    if (resAcc) res_valid = 1'b0;
    resAcc = 0;
    if (startReq) begin
      startReq = 0;
      start = 1'b1;
      startCycle = cycle;
      expFrame++;
      for (int i = 0; i < int'(num_checks); i++)
        expIss.push_back('{tag: {expFrame, AW'(i)}, data: mem[i]});
      reads = 0; issues = 0; writes = 0; doneCnt = 0; doneCycle = -1;
      firstRd = -1; firstValid = -1; outst = 0; maxOut = 0;
      stallUntil = cycle + stallLen;
      busyUntil = cycle + busyLen;
    end
    pipe_ready = (readyMode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    if (!res_valid && pipeQ.size() > 0 && pipeQ[0].readyAt <= cycle && cycle >= stallUntil) begin
      res_valid = 1'b1;
      res_tag = pipeQ[0].tag;
      res_data = pipeQ[0].data;
      void'(pipeQ.pop_front());
    end
    pipe_busy = (cycle < busyUntil) || (pipeQ.size() > 0) || res_valid;
    #1;
    if (rd_en) begin
      reads++;
      outst++;
      if (firstRd < 0) firstRd = cycle - startCycle;
      pendRd = mem[rd_addr];
    end
    if (pipe_valid && firstValid < 0) firstValid = cycle - startCycle;
    if (heldValid) check("stall_hold", {pipe_valid, pipe_tag, pipe_data}, {1'b1, heldTag, heldData});
    heldValid = pipe_valid && !pipe_ready;
    heldTag = pipe_tag;
    heldData = pipe_data;
    if (pipe_valid && pipe_ready) begin
      issues++;
      if (expIss.size() == 0) fail("issue_extra", "got an unexpected issue, expected none");
      else begin
        e = expIss.pop_front();
        check("issue_tag", pipe_tag, e.tag);
        check("issue_data", pipe_data, e.data);
      end
      t = pipe_tag;
      if (int'(pipe_tag[AW-1:0]) == corruptIdx) t[TW-1:AW] = '0;
      pipeQ.push_back('{tag: t, data: proj(pipe_data), readyAt: cycle + delay});
    end
    if (res_valid && res_ready) begin
      resAcc = 1;
      outst--;
      if (res_tag[TW-1:AW] == expFrame) expWr.push_back('{addr: res_tag[AW-1:0], data: res_data});
    end
    if (outst > maxOut) maxOut = outst;
    if (wr_en) begin
      writes++;
      if (expWr.size() == 0) fail("wr_extra", "got an unexpected write, expected none");
      else begin
        w = expWr.pop_front();
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", wr_data, w.data);
      end
    end
    if (done) begin
      doneCnt++;
      doneCycle = cycle - startCycle;
    end
  end

  task automatic checkIdleOutputs(input string name);
    check({name, "_ctrl"}, {idle, done, tag_error, rd_en, pipe_valid, res_ready, wr_en}, 7'b1000000);
    check({name, "_data"}, {rd_addr, pipe_tag, pipe_data, wr_addr, wr_data}, '0);
  endtask

  task automatic runCase(input caseT c);
    num_checks = AW'(c.n);
    readyMode = c.readyMode;
    delay = c.delay;
    stallLen = c.stall;
    busyLen = c.busyHold;
    corruptIdx = c.corruptIdx;
    startReq = 1;
    @(negedge clk); #2;
    for (int i = 0; i < 3000 && doneCnt == 0; i++) begin
      @(negedge clk); #2;
    end
    if (doneCnt == 0) fail("done_timeout", "no done within 3000 cycles, expected one");
    repeat (3) begin
      @(negedge clk); #2;
    end
    check("rd_count", reads, c.n);
    check("issue_count", issues, c.n);
    check("wr_count", writes, c.n - ((c.corruptIdx >= 0) ? 1 : 0));
    check("done_pulses", doneCnt, 1);
    check("idle_after", idle, 1);
    check("tag_error", tag_error, c.expTagErr);
    check("issue_left", expIss.size(), 0);
    if (c.expDone >= 0) check("done_cycle", doneCycle, c.expDone);
    if (c.expMaxOut >= 0) check("max_outstanding", maxOut, c.expMaxOut);
    if (c.n > 0) begin
      check("first_rd_cycle", firstRd, 1);
      check("first_valid_cycle", firstValid, 3);
    end
  endtask

  initial begin
    caseT cases[6];
    caseT post;
    cases[0] = '{n: 4,  readyMode: 1, delay: 5, stall: 0,  busyHold: 0,  corruptIdx: -1, expDone: 13, expMaxOut: 4,  expTagErr: 0};
    cases[1] = '{n: 40, readyMode: 1, delay: 3, stall: 50, busyHold: 0,  corruptIdx: -1, expDone: -1, expMaxOut: 16, expTagErr: 0};
    cases[2] = '{n: 25, readyMode: 2, delay: 4, stall: 0,  busyHold: 0,  corruptIdx: -1, expDone: -1, expMaxOut: -1, expTagErr: 0};
    cases[3] = '{n: 0,  readyMode: 1, delay: 1, stall: 0,  busyHold: 10, corruptIdx: -1, expDone: 11, expMaxOut: 0,  expTagErr: 0};
    cases[4] = '{n: 6,  readyMode: 1, delay: 2, stall: 0,  busyHold: 0,  corruptIdx: 2,  expDone: -1, expMaxOut: -1, expTagErr: 1};
    cases[5] = '{n: 3,  readyMode: 1, delay: 1, stall: 0,  busyHold: 0,  corruptIdx: -1, expDone: -1, expMaxOut: -1, expTagErr: 0};
    post     = '{n: 2,  readyMode: 1, delay: 1, stall: 0,  busyHold: 0,  corruptIdx: -1, expDone: -1, expMaxOut: -1, expTagErr: 0};
    for (int i = 0; i < (1 << AW); i++) mem[i] = VW'($urandom);

    repeat (2) @(negedge clk);
    #2;
    checkIdleOutputs("reset_state");
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    foreach (cases[i]) runCase(cases[i]);

    // Reset in the middle of a frame, with stale pipeline results still being offered.
    num_checks = AW'(20);
    readyMode = 1; delay = 2; stallLen = 0; busyLen = 0; corruptIdx = -1;
    startReq = 1;
    @(negedge clk); #2;
    for (int i = 0; i < 200 && issues < 7; i++) begin
      @(negedge clk); #2;
    end
    if (issues < 7) fail("midrst_wait", "fewer than 7 issues within 200 cycles, expected 7");
    @(posedge clk); #2;
    reset = 1'b0;
    expIss.delete();
    expWr.delete();
    heldValid = 0;
    expFrame = '0;
    repeat (4) begin
      @(negedge clk); #2;
      checkIdleOutputs("midrst");
    end
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk); #2;
      checkIdleOutputs("stale_results");
    end
    @(posedge clk); #2;
    pipeQ.delete();
    res_valid = 1'b0;
    outst = 0;
    runCase(post);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/projection_issuer.md
# projection_issuer

Frame-level driver for the check-node projection pipeline: on `start` it reads `num_checks` input vectors from the check-side memory, tags each with its check index and a frame id, and issues them into the projection pipeline's ready/valid input. It is also the consumer of that pipeline's output: it accepts each result, writes it back to memory at the index carried in its tag, and reports `done` once every issued vector has returned and the pipeline is empty.

## Interface
- TAG_WIDTH, 32, width of the tag sent to and returned from the pipeline
- BLOCKLENGTH, 1, vector components
- DATA_WIDTH, 8, bits per component
- ADDR_WIDTH, 10, check index / memory address width; must be < TAG_WIDTH
- MAX_OUTSTANDING, 16, credit limit: reads issued but results not yet returned (≥2)

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  one-cycle frame start request, honoured only in IDLE
- num_checks  in  ADDR_WIDTH  vectors in frame, latched on accepted start; 0 legal
- idle  out  1  high in IDLE
- done  out  1  one-cycle pulse at frame completion
- tag_error  out  1  sticky; result with wrong frame id seen; cleared on accepted start
- rd_en  out  1  memory read request
- rd_addr  out  ADDR_WIDTH  read address; data returns exactly 1 cycle later
- rd_data  in  DATA_WIDTH*BLOCKLENGTH  read data
- pipe_valid  out  1  vector offered to pipeline
- pipe_tag  out  TAG_WIDTH  {frame_id, check index}
- pipe_data  out  DATA_WIDTH*BLOCKLENGTH  vector
- pipe_ready  in  1  pipeline ready_out
- pipe_busy  in  1  pipeline busy
- res_valid  in  1  pipeline valid_out
- res_tag  in  TAG_WIDTH  returned tag
- res_data  in  DATA_WIDTH*BLOCKLENGTH  projected vector
- res_ready  out  1  drives the pipeline's ready_in
- wr_en, wr_addr (ADDR_WIDTH), wr_data (DATA_WIDTH*BLOCKLENGTH)  out  write-back port, always accepted

## Operation
- Transfer on either interface occurs when valid && ready in the same cycle; pipe_valid/pipe_tag/pipe_data held stable until accepted.
- Tag: low ADDR_WIDTH bits = check index; upper TAG_WIDTH-ADDR_WIDTH bits = frame_id, incremented (wrapping) on each accepted start.
- FSM IDLE → RUN on start. RUN → DRAIN when fetch_idx == N, no read in flight and prefetch FIFO empty (same cycle for N=0). DRAIN → DONE when credits == 0 and !pipe_busy. DONE → IDLE unconditionally; done high for that one cycle.
- rd_en in RUN when fetch_idx < N, credits < MAX_OUTSTANDING, FIFO occupancy + reads in flight < 2. rd_addr = fetch_idx, which then increments.
- Credits: +1 on rd_en, −1 on accepted result; both in one cycle → unchanged. Never exceeds MAX_OUTSTANDING.
- Prefetch FIFO (2 entries) captures rd_data the cycle after rd_en, with its index; head drives pipe_*. Full-throughput: one issue per cycle sustained while pipe_ready high.
- res_ready high in RUN and DRAIN, low otherwise. Accepted result: frame field == frame_id → wr_en next cycle with wr_addr = index field, wr_data = res_data. Mismatch → dropped, no write, tag_error set; credit still returned.
- start outside IDLE ignored. num_checks sampled only at accepted start.

## Timing
- Reset values: idle=1, all other outputs 0; frame_id=0, credits=0, FIFO empty, state IDLE.
- start at cycle 0 → RUN, first rd_en in cycle 1; rd_data captured end of cycle 2; pipe_valid first high in cycle 3.
- Result accepted in cycle k → wr_en in cycle k+1.
- DRAIN exit condition true in cycle k → done in cycle k+1, idle in cycle k+2.
- N=0: start at 0 → done in cycle 3 if pipe_busy low.
- Reset asserted mid-frame: immediate return to reset values; in-flight read data and pipeline results arriving afterwards are ignored (res_ready low in IDLE).

## Structure
- Shared package: state encoding, tag field split (index/frame_id widths), ceil-log2 function for counter widths.
- One sub-module: prefetch_fifo2 (2-entry FIFO, data+index, push/pop/occupancy, simultaneous push/pop when full allowed when popping).

## Test plan
- N=4, pipe_ready tied high, pipeline modelled as 5-cycle delay → tags index 0..3 frame 1 issued in cycles 3..6, four writes at addr 0..3, single done pulse.
- N=40, MAX_OUTSTANDING=16, pipeline stalls results 50 cycles → credits saturate at 16, rd_en stops, resumes after first result, all 40 written.
- pipe_ready toggled random 50% → pipe_* stable while stalled, no vector lost or duplicated, order 0..N-1.
- N=0 with pipe_busy held high 10 cycles → done only after pipe_busy falls; no rd_en, no pipe_valid.
- Inject result with frame_id 0 during frame 1 → no wr_en, tag_error=1, done still asserted; next start clears tag_error.
- Reset low mid-frame (N=20, after 7 issues) → all outputs to reset values; next start gives frame_id 1, index 0.
